// File: rtl/cp0_exc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_seq_if
// Description : Groups the CP0 / ID-stage / PC-redirect signals that connect
//               the exception sequencer to the rest of the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_exc_seq_if;
  logic [5:0]  int_req;
  logic        id_valid;
  logic        id_stall;
  logic        id_eret;
  logic [29:0] epc;
  logic        exl_set;
  logic        exl_clr;
  logic        flush_ifid;
  logic        hold_pc;
  logic        pc_redirect;
  logic [29:0] redirect_pc;
  logic        busy;

  modport master (
    input  int_req, id_valid, id_stall, id_eret, epc,
    output exl_set, exl_clr, flush_ifid, hold_pc, pc_redirect, redirect_pc, busy
  );

  modport slave (
    output int_req, id_valid, id_stall, id_eret, epc,
    input  exl_set, exl_clr, flush_ifid, hold_pc, pc_redirect, redirect_pc, busy
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_seq.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_seq
// Description : Interrupt-entry / ERET-return sequencer around CP0. Drains the
//               back end, then redirects the PC to the handler or to EPC.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_seq #(
  parameter logic [29:0] HANDLER_PC   = 30'h0000_1060,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  cp0_exc_seq_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INT_DRAIN = 3'd1,
    S_INT_GO    = 3'd2,
    S_RET_DRAIN = 3'd3,
    S_RET_GO    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DRAIN_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [29:0]      r_redirect_pc;
  logic [29:0]      w_redirect_pc;
  logic             w_accept;
  logic             w_exl_set;
  logic             w_exl_clr;
  logic             w_flush_ifid;
  logic             w_hold_pc;
  logic             w_pc_redirect;

  // Bubbles and stalled instructions never start a sequence, so EPC is always
  // the PC of a real instruction.
  assign w_accept = bus.id_valid && !bus.id_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_redirect_pc <= w_redirect_pc;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_redirect_pc = r_redirect_pc;
    w_exl_set     = 1'b0;
    w_exl_clr     = 1'b0;
    w_flush_ifid  = 1'b0;
    w_hold_pc     = 1'b0;
    w_pc_redirect = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // ERET wins over a coincident interrupt request.
          if (bus.id_eret) begin
            w_state_nxt = S_RET_DRAIN;
            w_cnt_nxt   = c_cnt_load;
          end else if (|bus.int_req) begin
            w_exl_set    = 1'b1;
            w_flush_ifid = 1'b1;
            w_state_nxt  = S_INT_DRAIN;
            w_cnt_nxt    = c_cnt_load;
          end
        end
      end
      S_INT_DRAIN: begin
        w_hold_pc    = 1'b1;
        w_flush_ifid = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_INT_GO;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_INT_GO: begin
        w_pc_redirect = 1'b1;
        w_redirect_pc = HANDLER_PC;
        w_state_nxt   = S_IDLE;
      end
      S_RET_DRAIN: begin
        // Draining also lets an in-flight MTC0 EPC land before epc is used.
        w_hold_pc    = 1'b1;
        w_flush_ifid = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_RET_GO;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RET_GO: begin
        w_pc_redirect = 1'b1;
        w_redirect_pc = bus.epc;
        w_exl_clr     = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control strobes are forced low while reset is held so nothing escapes
  // from a sequence that is being aborted.
  assign bus.exl_set     = w_exl_set     & ~rst;
  assign bus.exl_clr     = w_exl_clr     & ~rst;
  assign bus.flush_ifid  = w_flush_ifid  & ~rst;
  assign bus.hold_pc     = w_hold_pc     & ~rst;
  assign bus.pc_redirect = w_pc_redirect & ~rst;
  assign bus.busy        = (r_state != S_IDLE) & ~rst;
  assign bus.redirect_pc = w_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exc_seq
// Description : Directed, table-driven bench for the CP0 exception sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_seq;

  localparam int          c_drain = 3;
  localparam logic [29:0] c_hpc   = 30'h0000_1060;

  // Expected 1-bit outputs packed as {exl_set, exl_clr, flush, hold, redirect, busy}
  localparam logic [5:0] c_f0    = 6'b000000;
  localparam logic [5:0] c_ftake = 6'b101000;
  localparam logic [5:0] c_fdrn  = 6'b001101;
  localparam logic [5:0] c_figo  = 6'b000011;
  localparam logic [5:0] c_frgo  = 6'b010011;

  typedef struct packed {
    logic        rst;
    logic [5:0]  int_req;
    logic        v;
    logic        s;
    logic        e;
    logic [29:0] epc;
    logic [5:0]  flags;
    logic [29:0] rpc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[36];

  always #5 clk = ~clk;

  cp0_exc_seq_if bus();

  cp0_exc_seq #(
    .HANDLER_PC   (c_hpc),
    .DRAIN_CYCLES (c_drain),
    .CNT_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input logic r, input logic [5:0] ir, input logic v,
                              input logic s, input logic e, input logic [29:0] epc,
                              input logic [5:0] f, input logic [29:0] rpc);
    vec_t t;
    t = '{rst: r, int_req: ir, v: v, s: s, e: e, epc: epc, flags: f, rpc: rpc};
    return t;
  endfunction

  task automatic drive(input logic r, input logic [5:0] ir, input logic v,
                       input logic s, input logic e, input logic [29:0] epc);
    rst          = r;
    bus.int_req  = ir;
    bus.id_valid = v;
    bus.id_stall = s;
    bus.id_eret  = e;
    bus.epc      = epc;
  endtask

  function automatic logic [35:0] outs();
    return {bus.exl_set, bus.exl_clr, bus.flush_ifid, bus.hold_pc,
            bus.pc_redirect, bus.busy, bus.redirect_pc};
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs idle cycles until pc_redirect, returning the cycle count (bounded).
  task automatic wait_redirect(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 30'h0000_0155);
      #1;
      if (bus.pc_redirect) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;

    // Reset, then one interrupt take
    tbl[0]  = mk(1, 6'h04, 1, 0, 0, 30'h0, c_f0, 30'h0);
    tbl[1]  = mk(1, 6'h04, 1, 0, 0, 30'h0, c_f0, 30'h0);
    tbl[2]  = mk(0, 6'h01, 1, 0, 0, 30'h0, c_ftake, 30'h0);
    tbl[3]  = mk(0, 6'h00, 1, 0, 0, 30'h0, c_fdrn, 30'h0);
    tbl[4]  = mk(0, 6'h00, 1, 0, 0, 30'h0, c_fdrn, 30'h0);
    tbl[5]  = mk(0, 6'h00, 1, 0, 0, 30'h0, c_fdrn, 30'h0);
    tbl[6]  = mk(0, 6'h00, 1, 0, 0, 30'h0, c_figo, c_hpc);
    tbl[7]  = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, c_hpc);
    // Stall gating
    tbl[8]  = mk(0, 6'h02, 1, 1, 0, 30'h0, c_f0, c_hpc);
    tbl[9]  = mk(0, 6'h02, 1, 1, 0, 30'h0, c_f0, c_hpc);
    tbl[10] = mk(0, 6'h02, 1, 1, 0, 30'h0, c_f0, c_hpc);
    tbl[11] = mk(0, 6'h02, 1, 1, 0, 30'h0, c_f0, c_hpc);
    tbl[12] = mk(0, 6'h02, 1, 0, 0, 30'h0, c_ftake, c_hpc);
    tbl[13] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_fdrn, c_hpc);
    tbl[14] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_fdrn, c_hpc);
    tbl[15] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_fdrn, c_hpc);
    tbl[16] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_figo, c_hpc);
    // ERET return
    tbl[17] = mk(0, 6'h00, 1, 0, 1, 30'h0000_0C05, c_f0, c_hpc);
    tbl[18] = mk(0, 6'h00, 0, 0, 0, 30'h0000_0C05, c_fdrn, c_hpc);
    tbl[19] = mk(0, 6'h00, 0, 0, 0, 30'h0000_0C05, c_fdrn, c_hpc);
    tbl[20] = mk(0, 6'h00, 0, 0, 0, 30'h0000_0C05, c_fdrn, c_hpc);
    tbl[21] = mk(0, 6'h00, 0, 0, 0, 30'h0000_0C05, c_frgo, 30'h0000_0C05);
    tbl[22] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0000_0C05);
    // ERET with every interrupt line pending; requests ignored while draining
    tbl[23] = mk(0, 6'h3F, 1, 0, 1, 30'h0000_00AA, c_f0, 30'h0000_0C05);
    tbl[24] = mk(0, 6'h3F, 1, 0, 1, 30'h0000_00AA, c_fdrn, 30'h0000_0C05);
    tbl[25] = mk(0, 6'h3F, 1, 0, 1, 30'h0000_00AA, c_fdrn, 30'h0000_0C05);
    tbl[26] = mk(0, 6'h3F, 1, 0, 1, 30'h0000_00AA, c_fdrn, 30'h0000_0C05);
    tbl[27] = mk(0, 6'h00, 0, 0, 0, 30'h0000_00AA, c_frgo, 30'h0000_00AA);
    tbl[28] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0000_00AA);
    // Reset in the second drain cycle: no redirect afterwards
    tbl[29] = mk(0, 6'h01, 1, 0, 0, 30'h0, c_ftake, 30'h0000_00AA);
    tbl[30] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_fdrn, 30'h0000_00AA);
    tbl[31] = mk(1, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0000_00AA);
    tbl[32] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0);
    tbl[33] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0);
    tbl[34] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0);
    tbl[35] = mk(0, 6'h00, 0, 0, 0, 30'h0, c_f0, 30'h0);

    drive(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 30'h0);
    @(posedge clk);

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].int_req, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].epc);
      #1;
      check($sformatf("vec%0d", i), outs(), {tbl[i].flags, tbl[i].rpc});
    end

    // ERET then an interrupt accepted in the very next IDLE cycle
    @(negedge clk);
    drive(1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 30'h0000_0155);
    #1;
    wait_redirect(n);
    check("eret_latency", 36'(n), 36'(c_drain + 1));
    check("eret_go", outs(), {c_frgo, 30'h0000_0155});

    @(negedge clk);
    drive(1'b0, 6'h01, 1'b1, 1'b0, 1'b0, 30'h0000_0155);
    #1;
    check("b2b_take", outs(), {c_ftake, 30'h0000_0155});
    wait_redirect(n);
    check("int_latency", 36'(n), 36'(c_drain + 1));
    check("int_go", outs(), {c_figo, c_hpc});

    @(negedge clk);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 30'h0);
    #1;
    check("final_idle", outs(), {c_f0, c_hpc});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_exc_seq.md
Name: cp0_exc_seq

Overview:
- Sequencer that takes pipeline interrupts and ERET returns around the CP0 status/EPC block.
- Watches CP0's masked interrupt request and the ID stage.
- Drives CP0's EXL set/clear controls, flushes and holds the front end, and redirects the PC to the handler or back to EPC.
- Sits between CP0, the ID stage and the PC/IF logic; it is the only source of exl_set and exl_clr.

Parameters:
- HANDLER_PC, 30'h0000_1060 (word address bits 31:2): interrupt handler entry.
- DRAIN_CYCLES, 3: cycles to hold the front end so EX/MEM/WB retire before a redirect. Legal range is 1..15.
- CNT_W, 4: width of the drain counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- int_req  in  6  CP0 masked request (HWInt & IM & IE & !EXL); any nonzero bit means pending.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_stall  in  1  ID is held by a hazard this cycle.
- id_eret  in  1  the ID instruction decodes as ERET.
- epc  in  30  current CP0 EPC, bits 31:2.
- exl_set  out  1  to CP0 ExlSet; CP0 latches EPC = ID PC+4 on this edge.
- exl_clr  out  1  to CP0 ExlClr.
- flush_ifid  out  1  replaces the IF/ID register with a bubble at the next edge.
- hold_pc  out  1  freezes PC and IF/ID.
- pc_redirect  out  1  PC loads redirect_pc at the next edge.
- redirect_pc  out  30  redirect target, bits 31:2.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: state = IDLE, cnt = 0, redirect_pc = 0. All 1-bit outputs are 0 in the cycle after rst and for as long as rst is high. Reset aborts any sequence mid-flight; no pending redirect is retained.
- States: IDLE, INT_DRAIN, INT_GO, RET_DRAIN, RET_GO.
- IDLE, when id_valid && !id_stall:
  - If id_eret = 1: go to RET_DRAIN, cnt = DRAIN_CYCLES-1. ERET has priority over any simultaneous int_req.
  - Else if |int_req: in the same cycle assert exl_set = 1 and flush_ifid = 1 (combinational). The ID instruction completes normally; the IF instruction is killed. Go to INT_DRAIN, cnt = DRAIN_CYCLES-1.
- IDLE, otherwise: no output is asserted. int_req is ignored while id_valid = 0 or id_stall = 1, so no interrupt is taken on a bubble and EPC is never a bubble's PC.
- INT_DRAIN:
  - hold_pc = 1, flush_ifid = 1.
  - If cnt == 0, go to INT_GO; else cnt decrements.
- INT_GO:
  - pc_redirect = 1, redirect_pc = HANDLER_PC, hold_pc = 0.
  - Next state IDLE.
- RET_DRAIN:
  - hold_pc = 1, flush_ifid = 1. This lets a preceding MTC0 EPC write in EX/MEM land before epc is sampled.
  - Same counting rule as INT_DRAIN; on cnt == 0 go to RET_GO.
- RET_GO:
  - pc_redirect = 1, redirect_pc = epc (sampled this cycle), exl_clr = 1.
  - Next state IDLE.
- Outside IDLE, int_req, id_eret and id_stall are ignored.
- exl_set and exl_clr are never high in the same cycle. Each is a single-cycle pulse per sequence.
- busy = (state != IDLE).
- Latency:
  - Interrupt acceptance edge to handler fetch = DRAIN_CYCLES + 1 edges.
  - ERET acceptance edge to return fetch = DRAIN_CYCLES + 1 edges.
- Back-to-back: IDLE after RET_GO may immediately accept a new interrupt on the next cycle. The EXL clear lands at the RET_GO edge, so CP0's int_req is valid again one cycle later.
- redirect_pc holds its last value when pc_redirect = 0.

Test Plan:
- Reset check: rst = 1 for 2 cycles while int_req = 6'h04 and id_valid = 1 -> all outputs 0 and busy = 0 throughout.
- Interrupt take: id_valid = 1, id_stall = 0, int_req = 6'h01 for one cycle -> exl_set and flush_ifid pulse that cycle. Then hold_pc = 1 for exactly 3 cycles. Then pc_redirect = 1 with redirect_pc = 30'h0000_1060 for exactly 1 cycle, then busy = 0.
- Stall gating: int_req = 6'h02 with id_stall = 1 for 4 cycles -> no exl_set. Drop id_stall -> exl_set in that same cycle.
- ERET return: id_eret = 1, id_valid = 1, epc = 30'h0000_0C05 -> 3 hold cycles, then pc_redirect = 1 with redirect_pc = 30'h0000_0C05 and exl_clr = 1 in that same cycle.
- Simultaneous request: id_eret = 1 with int_req = 6'h3F -> ERET sequence only; exl_set never asserted.
- Reset mid-sequence: assert rst in the second INT_DRAIN cycle -> next cycle IDLE, no pc_redirect ever issued.
